answer_round_ctrl: RTL
======================

Name: answer_round_ctrl

Overview:
Round sequencer for the guessing game that owns the PRNG answer source. On a new-game request it pulses the PRNG's change_answer, waits for its write_enable, validates and latches the 8-digit answer, then accepts guesses through a valid/ready handshake. Each guess is scored digit-serially, and the block tracks remaining tries and the win/lose/error status for the display/UI logic.

Parameters:
MAX_TRIES, 10, guesses allowed per round (1..15)
WE_TIMEOUT, 15, cycles to wait for rng_we after a change_answer pulse
MAX_RETRY, 3, answer requests allowed (timeout or invalid answer) before error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
new_game  in  1  start/restart request, sampled per cycle
change_answer  out  1  one-cycle pulse to PRNG requesting a new answer
rng_value  in  32  PRNG answer: 8 nibbles, digit i = bits 4i+3:4i
rng_we  in  1  PRNG write_enable; value is valid in this cycle
guess  in  32  guess, same nibble layout as rng_value
guess_valid  in  1  guess offered
guess_ready  out  1  guess can be accepted
result_valid  out  1  one-cycle pulse; strikes valid
strikes  out  4  count of positions where guess digit equals answer digit (0..8)
tries_left  out  4  remaining guesses
win  out  1  held high in WON
lose  out  1  held high in LOST
busy  out  1  high in REQ, WAIT_WE, CHECK, RESULT
err  out  1  held high in ERR

Behaviour:
- Reset (async): state IDLE; all outputs 0; answer register 0; retry, timer and digit index 0.
- States: IDLE, REQ, WAIT_WE, READY, CHECK, RESULT, WON, LOST, ERR.
- new_game is honoured in IDLE, READY, WON, LOST and ERR. It goes to REQ, clears retry, win, lose and err, and sets tries_left=0. It is ignored in all other states.
- REQ: change_answer=1 for exactly this one cycle, timer cleared. Next state is WAIT_WE.
- WAIT_WE: the timer increments each cycle.
  - If rng_we=1 and all 8 nibbles are in 1..8: latch rng_value, set tries_left=MAX_TRIES, go to READY.
  - If rng_we=1 with any nibble 0 or >8, or if the timer reaches WE_TIMEOUT: increment retry. If retry is then < MAX_RETRY, go to REQ; otherwise go to ERR.
  - rng_we in any other state is ignored.
- READY: guess_ready=1. When guess_valid and guess_ready are both high (cycle T), latch guess, clear the strike count and digit index, and go to CHECK. guess_valid without ready has no effect.
- CHECK: one nibble per cycle, index 0..7, at T+1..T+8. A strike is counted when the nibbles match. After index 7, go to RESULT.
- RESULT (T+9): result_valid=1 and strikes holds its value until the next RESULT.
  - strikes==8: go to WON.
  - Otherwise decrement tries_left. If it is now 0, go to LOST; else go to READY.
- WON and LOST hold; win/lose are driven high.
- ERR holds err=1.
- guess_ready is 0 outside READY. change_answer is 0 outside REQ.
- A new_game arriving in the same cycle as a guess handshake in READY: new_game wins and the guess is dropped.

Optional Feature:
ANSWER_REVEAL_EN
- Defined: adds output answer_reveal[31:0], equal to the latched answer in READY, CHECK, RESULT, WON and LOST, and 0 otherwise (debug/demo mode).
- Undefined: the port is absent and the answer is never visible outside the block.

Decomposition:
- Shared package game_pkg holds:
  - DIGIT_W=4, NUM_DIGITS=8 and DIGIT_MIN=1 / DIGIT_MAX=8 constants.
  - The state enum for this block.
  - A digit_ok function implementing the 1..8 range check.
- One sub-module, answer_validator: combinational, checks all 8 nibbles of rng_value and returns a single valid bit. It is reused by the guess-entry logic.

Test Plan:
1. new_game, then rng_we 2 cycles after the change_answer pulse with 0x12345678 -> READY, tries_left=10, guess_ready=1.
2. Guess 0x12345687 -> result_valid at T+9, strikes=6, tries_left=9, back in READY.
3. Guess 0x12345678 -> strikes=8, win=1, guess_ready=0. A further guess_valid is ignored.
4. First rng_value 0x02345678 with rng_we, then 0x11111111 -> second change_answer pulse, answer 0x11111111 accepted.
5. rng_we never asserted -> three change_answer pulses, each 16 cycles apart, then err=1. A subsequent new_game clears err and re-requests.
6. 10 wrong guesses -> lose=1 after the 10th result, tries_left=0.
7. rst asserted mid-CHECK -> immediate IDLE, all outputs 0. The next new_game starts cleanly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, round-sequencer state encoding and digit range check for the guessing game.
package game_pkg;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_WE, S_READY, S_CHECK, S_RESULT, S_WON, S_LOST, S_ERR
  } arc_state_e;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_MIN) && (d <= DIGIT_MAX);
  endfunction
endpackage

// File: rtl/answer_round_ctrl_if.sv
// Game-side bus of answer_round_ctrl: PRNG handshake, guess entry and status.
// answer_reveal exists only when ANSWER_REVEAL_EN is defined.
interface answer_round_ctrl_if;
  import game_pkg::*;
  logic              new_game;
  logic              change_answer;
  logic [WORD_W-1:0] rng_value;
  logic              rng_we;
  logic [WORD_W-1:0] guess;
  logic              guess_valid;
  logic              guess_ready;
  logic              result_valid;
  logic [3:0]        strikes;
  logic [3:0]        tries_left;
  logic              win;
  logic              lose;
  logic              busy;
  logic              err;
`ifdef ANSWER_REVEAL_EN
  logic [WORD_W-1:0] answer_reveal;
`endif

  modport slave (
`ifdef ANSWER_REVEAL_EN
    output answer_reveal,
`endif
    input  new_game, rng_value, rng_we, guess, guess_valid,
    output change_answer, guess_ready, result_valid, strikes, tries_left,
           win, lose, busy, err
  );

  modport master (
`ifdef ANSWER_REVEAL_EN
    input  answer_reveal,
`endif
    output new_game, rng_value, rng_we, guess, guess_valid,
    input  change_answer, guess_ready, result_valid, strikes, tries_left,
           win, lose, busy, err
  );
endinterface

// File: rtl/answer_validator.sv
// Combinational check that every nibble of an 8-digit word lies in the playable digit range.
module answer_validator
  import game_pkg::*;
(
  input  logic [WORD_W-1:0] value_i,
  output logic              valid_o
);
  logic [NUM_DIGITS-1:0] ok;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign ok[i] = digit_ok(value_i[i*DIGIT_W +: DIGIT_W]);
  end

  assign valid_o = &ok;
endmodule

// File: rtl/answer_round_ctrl.sv
// Round sequencer: fetches and validates a PRNG answer, scores guesses digit-serially, tracks tries.
// Define ANSWER_REVEAL_EN to expose the latched answer on answer_reveal.
module answer_round_ctrl
  import game_pkg::*;
#(
  parameter int MAX_TRIES  = 10,
  parameter int WE_TIMEOUT = 15,
  parameter int MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               rst,
  answer_round_ctrl_if.slave bus
);
  localparam int TW = $clog2(WE_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  arc_state_e        state_q;
  logic [WORD_W-1:0] answer_q, guess_q;
  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q, retry_d;
  logic [2:0]        idx_q;
  logic [3:0]        cnt_q, cnt_d, strikes_q, tries_q;
  logic              rng_ok, match;

  answer_validator u_val (.value_i(bus.rng_value), .valid_o(rng_ok));

  assign retry_d = retry_q + RW'(1);
  assign match   = guess_q[idx_q*DIGIT_W +: DIGIT_W] == answer_q[idx_q*DIGIT_W +: DIGIT_W];
  assign cnt_d   = cnt_q + {3'b000, match};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      answer_q  <= '0;
      guess_q   <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      strikes_q <= '0;
      tries_q   <= '0;
    end else if (bus.new_game && (state_q inside {S_IDLE, S_READY, S_WON, S_LOST, S_ERR})) begin
      // Restart beats a same-cycle guess handshake in READY.
      state_q <= S_REQ;
      retry_q <= '0;
      tries_q <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          timer_q <= '0;
          state_q <= S_WAIT_WE;
        end
        S_WAIT_WE: begin
          timer_q <= timer_q + TW'(1);
          if (bus.rng_we && rng_ok) begin
            answer_q <= bus.rng_value;
            tries_q  <= 4'(MAX_TRIES);
            state_q  <= S_READY;
          end else if (bus.rng_we || timer_q == TW'(WE_TIMEOUT - 1)) begin
            retry_q <= retry_d;
            state_q <= (retry_d < RW'(MAX_RETRY)) ? S_REQ : S_ERR;
          end
        end
        S_READY: if (bus.guess_valid) begin
          guess_q <= bus.guess;
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          cnt_q <= cnt_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            strikes_q <= cnt_d;
            state_q   <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (strikes_q == 4'd8) begin
            state_q <= S_WON;
          end else begin
            tries_q <= tries_q - 4'd1;
            state_q <= (tries_q == 4'd1) ? S_LOST : S_READY;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.change_answer = state_q == S_REQ;
  assign bus.guess_ready   = state_q == S_READY;
  assign bus.result_valid  = state_q == S_RESULT;
  assign bus.strikes       = strikes_q;
  assign bus.tries_left    = tries_q;
  assign bus.win           = state_q == S_WON;
  assign bus.lose          = state_q == S_LOST;
  assign bus.err           = state_q == S_ERR;
  assign bus.busy          = state_q inside {S_REQ, S_WAIT_WE, S_CHECK, S_RESULT};
`ifdef ANSWER_REVEAL_EN
  assign bus.answer_reveal = (state_q inside {S_READY, S_CHECK, S_RESULT, S_WON, S_LOST})
                             ? answer_q : '0;
`endif
endmodule
